// File: rtl/dllp_ack_decoder.sv
// Receive-side Ack/Nak DLLP decoder: reassembles 3-word DLLPs, verifies CRC-16 and
// emits a one-cycle ack_nack strobe with the sequence number for the replay buffer.
module dllp_ack_decoder #(
    parameter logic [7:0]  ACK_TYPE = 8'h00,
    parameter logic [7:0]  NAK_TYPE = 8'h10,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din_valid,
    input  logic        din_sop,
    input  logic [15:0] din,
    output logic [1:0]  ack_nack,
    output logic [11:0] seq,
    output logic [7:0]  crc_err_cnt,
    output logic [7:0]  drop_cnt
);

    localparam logic [15:0] CRC_POLY = 16'h100B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT0  = 2'd1,
        GOT1  = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  type_q;
    logic [11:0] seq_q;
    logic [15:0] crc_q;
    logic [15:0] w2_q;

    // Sixteen MSB-first steps of the CRC-16 LFSR, folding one whole word per cycle.
    function automatic logic [15:0] crc_word(input logic [15:0] crc_in, input logic [15:0] word);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            type_q      <= 8'h00;
            seq_q       <= 12'h000;
            crc_q       <= CRC_INIT;
            w2_q        <= 16'h0000;
            ack_nack    <= 2'b00;
            seq         <= 12'h000;
            crc_err_cnt <= 8'h00;
            drop_cnt    <= 8'h00;
        end else begin
            ack_nack <= 2'b00;
            case (state)
                IDLE: begin
                    if (din_valid && din_sop) begin
                        type_q <= din[15:8];
                        crc_q  <= crc_word(CRC_INIT, din);
                        state  <= GOT0;
                    end
                end
                GOT0: begin
                    if (din_valid) begin
                        if (din_sop) begin
                            // A fresh sop abandons the partial frame and becomes its W0.
                            drop_cnt <= sat_inc(drop_cnt);
                            type_q   <= din[15:8];
                            crc_q    <= crc_word(CRC_INIT, din);
                            state    <= GOT0;
                        end else begin
                            seq_q <= din[11:0];
                            crc_q <= crc_word(crc_q, din);
                            state <= GOT1;
                        end
                    end
                end
                GOT1: begin
                    if (din_valid) begin
                        if (din_sop) begin
                            drop_cnt <= sat_inc(drop_cnt);
                            type_q   <= din[15:8];
                            crc_q    <= crc_word(CRC_INIT, din);
                            state    <= GOT0;
                        end else begin
                            w2_q  <= din;
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (w2_q != ~crc_q) begin
                        crc_err_cnt <= sat_inc(crc_err_cnt);
                    end else if (type_q == ACK_TYPE) begin
                        ack_nack <= 2'b01;
                        seq      <= seq_q;
                    end else if (type_q == NAK_TYPE) begin
                        ack_nack <= 2'b10;
                        seq      <= seq_q;
                    end else begin
                        drop_cnt <= sat_inc(drop_cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
